// File: rtl/exhaustive_response_checker_if.sv
// Handshake bundle between the capture harness and the exhaustive response checker:
// golden-table load port, run control, sample stream and verdict outputs.
interface exhaustive_response_checker_if #(
  parameter int N_IN = 6
);
  logic            gold_wr;
  logic [N_IN-1:0] gold_addr;
  logic            gold_data;
  logic            start;
  logic            sample_valid;
  logic [N_IN-1:0] sample_vec;
  logic            sample_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   mismatch_cnt;
  logic            first_fail_valid;
  logic [N_IN-1:0] first_fail_vec;
  logic            seq_err;

  modport master (
    output gold_wr, gold_addr, gold_data, start, sample_valid, sample_vec, sample_out,
    input  busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_vec, seq_err
  );

  modport slave (
    input  gold_wr, gold_addr, gold_data, start, sample_valid, sample_vec, sample_out,
    output busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_vec, seq_err
  );
endinterface

// File: rtl/exhaustive_response_checker.sv
// In-circuit verdict for an exhaustive 0..2^N_IN-1 response stream compared against
// a preloaded 1-bit golden truth table.
module exhaustive_response_checker #(
  parameter int N_IN = 6
) (
  input logic                          CK,
  input logic                          reset,
  exhaustive_response_checker_if.slave bus
);

  localparam int              DEPTH   = 1 << N_IN;
  localparam logic [N_IN:0]   CNT_MAX = (N_IN+1)'(DEPTH);
  localparam logic [N_IN:0]   CNT_ONE = (N_IN+1)'(1);
  localparam logic [N_IN-1:0] IDX_ONE = N_IN'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [DEPTH-1:0] gold;
  logic [N_IN-1:0] expect_idx;
  logic [N_IN:0]   mismatch_cnt;
  logic            pass, first_fail_valid, seq_err;
  logic [N_IN-1:0] first_fail_vec;

  logic accept, in_order, last_idx, mism;

  // start always wins over a coincident sample, which is simply dropped
  assign accept   = (state == RUN) && bus.sample_valid && !bus.start;
  assign in_order = (bus.sample_vec == expect_idx);
  assign last_idx = (expect_idx == '1);
  assign mism     = (bus.sample_out != gold[bus.sample_vec]);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        if (bus.start)                      state_nxt = RUN;
        else if (accept && !in_order)       state_nxt = DONE;
        else if (accept && last_idx)        state_nxt = DONE;
      end
      DONE: if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the golden table is a small flop array, so it takes the async reset like any
  // other register; a RAM macro could not be cleared this way.
  always_ff @(posedge CK or posedge reset) begin
    if (reset)                           gold <= '0;
    else if (bus.gold_wr && state != RUN) gold[bus.gold_addr] <= bus.gold_data;
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      expect_idx       <= '0;
      mismatch_cnt     <= '0;
      pass             <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      seq_err          <= 1'b0;
    end else if (bus.start) begin
      expect_idx       <= '0;
      mismatch_cnt     <= '0;
      pass             <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      seq_err          <= 1'b0;
    end else if (accept) begin
      if (!in_order) begin
        seq_err <= 1'b1;
        pass    <= 1'b0;
      end else begin
        if (mism && mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + CNT_ONE;
        if (mism && !first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_vec   <= bus.sample_vec;
        end
        // Verdict includes the final sample itself, hence the explicit !mism term
        if (last_idx) pass       <= (mismatch_cnt == '0) && !mism;
        else          expect_idx <= expect_idx + IDX_ONE;
      end
    end
  end

  assign bus.pass             = pass;
  assign bus.mismatch_cnt     = mismatch_cnt;
  assign bus.first_fail_valid = first_fail_valid;
  assign bus.first_fail_vec   = first_fail_vec;
  assign bus.seq_err          = seq_err;

endmodule

// File: tb/tb_exhaustive_response_checker.sv
// Self-checking bench for exhaustive_response_checker: directed scenarios plus randomized
// golden tables and responses scored against an array-based reference model.
module tb_exhaustive_response_checker;

  localparam int N_IN  = 6;
  localparam int DEPTH = 1 << N_IN;

  logic ck = 1'b0;
  logic reset;
  always #5 ck = ~ck;

  exhaustive_response_checker_if #(.N_IN(N_IN)) bus ();

  exhaustive_response_checker #(.N_IN(N_IN)) dut (
    .CK    (ck),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit model_gold [DEPTH];
  bit resp       [DEPTH];

  // Expected verdict for a full in-order run: plain count over the two arrays
  function automatic void model_expect(output int cnt, output int first, output bit pass_e);
    cnt   = 0;
    first = 0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (resp[i] != model_gold[i]) begin
        cnt++;
        first = i;
      end
    end
    pass_e = (cnt == 0);
  endfunction

  function automatic bit parity(input int i);
    logic [N_IN-1:0] v;
    v = i[N_IN-1:0];
    return ^v;
  endfunction

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input int vec, input bit out);
    bus.sample_valid = 1'b1;
    bus.sample_vec   = vec[N_IN-1:0];
    bus.sample_out   = out;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic stream(input int from, input int to, input int max_gap);
    for (int i = from; i <= to; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) tick();
      send(i, resp[i]);
    end
  endtask

  task automatic load_gold();
    for (int i = 0; i < DEPTH; i++) begin
      bus.gold_wr   = 1'b1;
      bus.gold_addr = i[N_IN-1:0];
      bus.gold_data = model_gold[i];
      tick();
    end
    bus.gold_wr = 1'b0;
  endtask

  task automatic set_parity_table();
    for (int i = 0; i < DEPTH; i++) begin
      model_gold[i] = parity(i);
      resp[i]       = model_gold[i];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b want 0", bus.pass); end
    n_checks++; if (bus.mismatch_cnt !== 7'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.mismatch_cnt); end
    n_checks++; if (bus.first_fail_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ffv: got %b want 0", bus.first_fail_valid); end
    n_checks++; if (bus.first_fail_vec !== 6'd0) begin n_fail++; $display("FAIL reset_ffvec: got %0d want 0", bus.first_fail_vec); end
    n_checks++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err: got %b want 0", bus.seq_err); end
  endtask

  task automatic test_clean_run();
    set_parity_table();
    load_gold();
    pulse_start();
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL clean_busy_after_start: got %b want 1", bus.busy); end
    stream(0, DEPTH - 2, 0);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL clean_done_early: got %b want 0 before last sample", bus.done); end
    stream(DEPTH - 1, DEPTH - 1, 0);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL clean_done: got %b want 1", bus.done); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clean_busy_end: got %b want 0", bus.busy); end
    n_checks++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL clean_pass: got %b want 1", bus.pass); end
    n_checks++; if (bus.mismatch_cnt !== 7'd0) begin n_fail++; $display("FAIL clean_cnt: got %0d want 0", bus.mismatch_cnt); end
    n_checks++; if (bus.first_fail_valid !== 1'b0) begin n_fail++; $display("FAIL clean_ffv: got %b want 0", bus.first_fail_valid); end
    n_checks++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL clean_seq_err: got %b want 0", bus.seq_err); end
  endtask

  task automatic test_two_mismatches();
    int cnt_e, first_e;
    bit pass_e;
    set_parity_table();
    resp[5]  = ~resp[5];
    resp[40] = ~resp[40];
    model_expect(cnt_e, first_e, pass_e);
    pulse_start();
    stream(0, 5, 0);
    n_checks++; if (bus.mismatch_cnt !== 7'd1) begin n_fail++; $display("FAIL mm_cnt_after_5: got %0d want 1", bus.mismatch_cnt); end
    n_checks++; if (bus.first_fail_valid !== 1'b1) begin n_fail++; $display("FAIL mm_ffv_after_5: got %b want 1", bus.first_fail_valid); end
    stream(6, DEPTH - 1, 0);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL mm_done: got %b want 1", bus.done); end
    n_checks++; if (bus.pass !== pass_e) begin n_fail++; $display("FAIL mm_pass: got %b want %b", bus.pass, pass_e); end
    n_checks++; if (int'(bus.mismatch_cnt) !== cnt_e) begin n_fail++; $display("FAIL mm_cnt: got %0d want %0d", bus.mismatch_cnt, cnt_e); end
    n_checks++; if (int'(bus.first_fail_vec) !== first_e) begin n_fail++; $display("FAIL mm_ffvec: got %0d want %0d", bus.first_fail_vec, first_e); end
  endtask

  task automatic test_seq_error();
    set_parity_table();
    pulse_start();
    n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL seq_pass_cleared: got %b want 0", bus.pass); end
    stream(0, 2, 0);
    send(4, resp[4]);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL seq_done: got %b want 1", bus.done); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL seq_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_err_set: got %b want 1", bus.seq_err); end
    n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL seq_pass: got %b want 0", bus.pass); end
    n_checks++; if (bus.mismatch_cnt !== 7'd0) begin n_fail++; $display("FAIL seq_cnt: got %0d want 0", bus.mismatch_cnt); end
    // Write accepted in DONE: flip entry 0, then a response matching the old value mismatches
    model_gold[0] = ~model_gold[0];
    bus.gold_wr = 1'b1; bus.gold_addr = '0; bus.gold_data = model_gold[0];
    tick();
    bus.gold_wr = 1'b0;
    pulse_start();
    n_checks++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_err_cleared: got %b want 0", bus.seq_err); end
    send(0, ~model_gold[0]);
    n_checks++; if (bus.mismatch_cnt !== 7'd1) begin n_fail++; $display("FAIL done_gold_wr_cnt: got %0d want 1", bus.mismatch_cnt); end
    n_checks++; if (bus.first_fail_vec !== 6'd0 || bus.first_fail_valid !== 1'b1) begin n_fail++; $display("FAIL done_gold_wr_ff: got v=%b vec=%0d want v=1 vec=0", bus.first_fail_valid, bus.first_fail_vec); end
  endtask

  task automatic test_restart_with_gaps();
    for (int i = 0; i < DEPTH; i++) resp[i] = model_gold[i];
    resp[3] = ~resp[3];
    pulse_start();
    stream(0, 9, 3);
    n_checks++; if (bus.mismatch_cnt !== 7'd1) begin n_fail++; $display("FAIL restart_pre_cnt: got %0d want 1", bus.mismatch_cnt); end
    // start together with a wrong sample 10: the sample must be dropped
    bus.start = 1'b1; bus.sample_valid = 1'b1; bus.sample_vec = 6'd10; bus.sample_out = ~model_gold[10];
    tick();
    bus.start = 1'b0; bus.sample_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b want 1", bus.busy); end
    n_checks++; if (bus.mismatch_cnt !== 7'd0) begin n_fail++; $display("FAIL restart_cnt: got %0d want 0", bus.mismatch_cnt); end
    n_checks++; if (bus.first_fail_valid !== 1'b0) begin n_fail++; $display("FAIL restart_ffv: got %b want 0", bus.first_fail_valid); end
    resp[3] = model_gold[3];
    stream(0, DEPTH - 1, 2);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b want 1", bus.done); end
    n_checks++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL restart_pass: got %b want 1", bus.pass); end
    n_checks++; if (bus.mismatch_cnt !== 7'd0) begin n_fail++; $display("FAIL restart_end_cnt: got %0d want 0", bus.mismatch_cnt); end
  endtask

  task automatic test_reset_mid_run();
    set_parity_table();
    load_gold();
    resp[12] = ~resp[12];
    pulse_start();
    stream(0, 30, 0);
    reset = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.mismatch_cnt !== 7'd0) begin n_fail++; $display("FAIL async_reset_cnt: got %0d want 0", bus.mismatch_cnt); end
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (bus.done !== 1'b0 || bus.pass !== 1'b0 || bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_flags: got done=%b pass=%b seq_err=%b want 0 0 0", bus.done, bus.pass, bus.seq_err); end
    n_checks++; if (bus.first_fail_valid !== 1'b0 || bus.first_fail_vec !== 6'd0) begin n_fail++; $display("FAIL midrun_reset_ff: got v=%b vec=%0d want 0 0", bus.first_fail_valid, bus.first_fail_vec); end
    // Cleared table: an all-zero response stream must pass without reloading
    for (int i = 0; i < DEPTH; i++) begin model_gold[i] = 1'b0; resp[i] = 1'b0; end
    pulse_start();
    stream(0, DEPTH - 1, 0);
    n_checks++; if (bus.pass !== 1'b1 || bus.mismatch_cnt !== 7'd0) begin n_fail++; $display("FAIL table_cleared: got pass=%b cnt=%0d want 1 0", bus.pass, bus.mismatch_cnt); end
    set_parity_table();
    load_gold();
    pulse_start();
    stream(0, DEPTH - 1, 1);
    n_checks++; if (bus.pass !== 1'b1 || bus.done !== 1'b1) begin n_fail++; $display("FAIL reload_pass: got pass=%b done=%b want 1 1", bus.pass, bus.done); end
  endtask

  task automatic test_gold_wr_in_run();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin model_gold[i] = 1'b0; resp[i] = 1'b0; end
    pulse_start();
    stream(0, 6, 0);
    bus.gold_wr = 1'b1; bus.gold_addr = 6'd7; bus.gold_data = 1'b1;
    tick();
    bus.gold_wr = 1'b0;
    stream(7, 7, 0);
    n_checks++; if (bus.mismatch_cnt !== 7'd0) begin n_fail++; $display("FAIL run_gold_wr_cnt: got %0d want 0", bus.mismatch_cnt); end
    stream(8, DEPTH - 1, 0);
    n_checks++; if (bus.pass !== 1'b1 || bus.first_fail_valid !== 1'b0) begin n_fail++; $display("FAIL run_gold_wr_pass: got pass=%b ffv=%b want 1 0", bus.pass, bus.first_fail_valid); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int cnt_e, first_e;
      bit pass_e;
      for (int i = 0; i < DEPTH; i++) begin
        model_gold[i] = 1'($urandom);
        resp[i]       = model_gold[i] ^ (($urandom_range(7, 0) == 0) && (it != 0));
      end
      model_expect(cnt_e, first_e, pass_e);
      load_gold();
      pulse_start();
      stream(0, DEPTH - 1, 2);
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rand%0d_done: got %b want 1", it, bus.done); end
      n_checks++; if (int'(bus.mismatch_cnt) !== cnt_e) begin n_fail++; $display("FAIL rand%0d_cnt: got %0d want %0d", it, bus.mismatch_cnt, cnt_e); end
      n_checks++; if (bus.pass !== pass_e) begin n_fail++; $display("FAIL rand%0d_pass: got %b want %b", it, bus.pass, pass_e); end
      n_checks++; if (bus.first_fail_valid !== (cnt_e > 0)) begin n_fail++; $display("FAIL rand%0d_ffv: got %b want %b", it, bus.first_fail_valid, cnt_e > 0); end
      n_checks++; if (int'(bus.first_fail_vec) !== first_e) begin n_fail++; $display("FAIL rand%0d_ffvec: got %0d want %0d", it, bus.first_fail_vec, first_e); end
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.gold_wr      = 1'b0;
    bus.gold_addr    = '0;
    bus.gold_data    = 1'b0;
    bus.start        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_vec   = '0;
    bus.sample_out   = 1'b0;

    test_reset();
    test_clean_run();
    test_two_mismatches();
    test_seq_error();
    test_restart_with_gaps();
    test_reset_mid_run();
    test_gold_wr_in_run();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
